// File: rtl/in_shift_reg.sv
// Serial-to-parallel receiver: N2 MSB-first lanes deserialized into a double-buffered
// frame of N2 words, unloaded one word per valid/ready transfer. Optional parity: IN_SHIFT_REG_PARITY_EN.
module in_shift_reg #(
  parameter int N1 = 90,
  parameter int N2 = 6
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ShiftEn,
  input  logic          Sync,
  input  logic [N2-1:0] SerialIn,
  output logic [N1-1:0] Out,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          OutLast,
  output logic          Overflow,
`ifdef IN_SHIFT_REG_PARITY_EN
  output logic [0:0]    ParErr,
`endif
  output logic          Busy
);

`ifdef IN_SHIFT_REG_PARITY_EN
  localparam int FB = N1 + 1;
`else
  localparam int FB = N1;
`endif
  localparam int CNT_W = $clog2(FB + 1);
  localparam int IDX_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N2 - 1);

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;
  typedef enum logic {UL_EMPTY, UL_UNLOAD} ul_state_e;

  rx_state_e        rx_q, rx_d;
  ul_state_e        ul_q, ul_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [FB-1:0]    shift_q [N2];
  logic [FB-1:0]    shift_d [N2];
  logic [N1-1:0]    hold_q  [N2];
  logic [N1-1:0]    hold_d  [N2];
`ifdef IN_SHIFT_REG_PARITY_EN
  logic [N2-1:0]    perr_q, perr_d;

  // Even parity over data plus parity bit: a 1 means the lane was corrupted.
  function automatic logic lane_parity(input logic [FB-1:0] bits);
    return ^bits;
  endfunction
`endif

  logic sample, complete, xfer, last_xfer, hold_free;

  // RX FSM: a Sync always restarts the frame, even mid-shift.
  always_comb begin
    rx_d     = rx_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sample   = 1'b0;
    complete = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (ShiftEn && Sync) begin
          rx_d   = RX_SHIFT;
          cnt_d  = CNT_W'(1);
          sample = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (ShiftEn) begin
          sample = 1'b1;
          if (Sync) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
            rx_d     = RX_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
    if (sample) begin
      for (int j = 0; j < N2; j++) begin
        shift_d[j] = {shift_q[j][FB-2:0], SerialIn[j]};
      end
    end
  end

  // Unload FSM; the hold bank counts as free when its last word leaves this cycle.
  always_comb begin
    ul_d      = ul_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    ovf_d     = ovf_q;
    xfer      = (ul_q == UL_UNLOAD) && OutReady;
    last_xfer = xfer && (idx_q == IDX_LAST);
    hold_free = (ul_q == UL_EMPTY) || last_xfer;
`ifdef IN_SHIFT_REG_PARITY_EN
    perr_d    = perr_q;
`endif
    if (xfer) begin
      if (last_xfer) begin
        idx_d = '0;
        ul_d  = UL_EMPTY;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (complete) begin
      if (hold_free) begin
        ul_d  = UL_UNLOAD;
        idx_d = '0;
        for (int j = 0; j < N2; j++) begin
          hold_d[j] = shift_d[j][FB-1 -: N1];
`ifdef IN_SHIFT_REG_PARITY_EN
          perr_d[j] = lane_parity(shift_d[j]);
`endif
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_q  <= RX_IDLE;
      ul_q  <= UL_EMPTY;
      cnt_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
      for (int j = 0; j < N2; j++) begin
        shift_q[j] <= '0;
        hold_q[j]  <= '0;
      end
`ifdef IN_SHIFT_REG_PARITY_EN
      perr_q <= '0;
`endif
    end else begin
      rx_q    <= rx_d;
      ul_q    <= ul_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
`ifdef IN_SHIFT_REG_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign OutValid = (ul_q == UL_UNLOAD);
  assign Out      = OutValid ? hold_q[idx_q] : '0;
  assign OutLast  = OutValid && (idx_q == IDX_LAST);
  assign Overflow = ovf_q;
  assign Busy     = (rx_q == RX_SHIFT);
`ifdef IN_SHIFT_REG_PARITY_EN
  assign ParErr   = OutValid && perr_q[idx_q];
`endif

endmodule
